// File: rtl/mod3_stream_arbiter_pkg.sv
// Shared encodings and helper for the mod-3 stream arbiter and its tracker.
// Latency: n/a (types and a pure combinational function only).
// Backpressure: n/a.
package fsm_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_STREAM = 2'b01,
    ST_RESULT = 2'b10
  } ctrl_state_e;

  // Running ones count modulo 3
  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10
  } mod3_state_e;

  // Next tracker state for one accepted bit; zeros leave the count alone.
  function automatic mod3_state_e MOD3_NEXT(input mod3_state_e s, input logic b);
    mod3_state_e n;
    n = s;
    if (b) begin
      case (s)
        S0:      n = S1;
        S1:      n = S2;
        default: n = S0;
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/mod3_stream_arbiter_if.sv
// Requester/consumer bundle of the mod-3 stream arbiter.
// Latency: n/a (wiring only).
// Backpressure: bit_valid/bit_ready per requester, res_valid/res_ready for the result.
interface mod3_stream_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int LEN_W = 8
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]       i_req;
  logic [N_REQ*LEN_W-1:0] i_len;
  logic [N_REQ-1:0]       i_bit_valid;
  logic [N_REQ-1:0]       i_bit;
  logic [N_REQ-1:0]       o_bit_ready;
  logic [N_REQ-1:0]       o_grant;
  logic                   o_busy;
  logic                   o_res_valid;
  logic                   o_res_z;
  logic [ID_W-1:0]        o_res_id;
  logic                   i_res_ready;

  // Producer/consumer side
  modport master (
    output i_req, i_len, i_bit_valid, i_bit, i_res_ready,
    input  o_bit_ready, o_grant, o_busy, o_res_valid, o_res_z, o_res_id
  );

  // Arbiter side
  modport slave (
    input  i_req, i_len, i_bit_valid, i_bit, i_res_ready,
    output o_bit_ready, o_grant, o_busy, o_res_valid, o_res_z, o_res_id
  );

endinterface

// File: rtl/mod3_stream_arbiter_tracker.sv
// Mod-3 ones counter shared by all requesters; clear wins over enable.
// Latency: state updates on the edge after an enabled bit.
// Backpressure: none, counts only when i_en is high.
module mod3_tracker
  import fsm_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic        i_bit,
  output mod3_state_e o_state,
  output logic        o_z
);

  mod3_state_e state_q, state_d;

  // Next count: clear at grant, otherwise advance on accepted bits
  always_comb begin
    state_d = state_q;
    if (i_clr)     state_d = S0;
    else if (i_en) state_d = MOD3_NEXT(state_q, i_bit);
  end

  // Count register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S0;
    else       state_q <= state_d;
  end

  assign o_state = state_q;
  assign o_z     = (state_q == S0);

endmodule

// File: rtl/mod3_stream_arbiter.sv
// Round-robin share of one mod-3 detector across N_REQ serial requesters.
// Latency: grant 1 cycle after the IDLE pick, result 1 cycle after the last bit.
// Backpressure: stalls on bit_valid bubbles; result held until i_res_ready.
module mod3_stream_arbiter
  import fsm_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int LEN_W = 8,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  mod3_stream_arbiter_if.slave bus
);

  ctrl_state_e     state_q, state_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [ID_W-1:0] last_id_q, last_id_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [ID_W-1:0] pick_id;
  logic [LEN_W-1:0] pick_len;
  logic            req_any;
  logic            xfer;
  logic            trk_clr;
  mod3_state_e     trk_state;
  logic            trk_z;

  assign req_any = |bus.i_req;
  assign xfer    = (state_q == ST_STREAM) && bus.i_bit_valid[id_q];

  // Round-robin pick: first set request above last_id, wrapping; smallest offset wins
  always_comb begin
    int              j;
    logic [ID_W-1:0] jj;
    pick_id  = '0;
    pick_len = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      j = int'(last_id_q) + k;
      if (j >= N_REQ) j = j - N_REQ;
      jj = ID_W'(j);
      if (bus.i_req[jj]) pick_id = jj;
    end
    for (int k = 0; k < N_REQ; k++) begin
      if (pick_id == ID_W'(k)) pick_len = bus.i_len[k*LEN_W +: LEN_W];
    end
  end

  // Controller state and frame bookkeeping
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      id_q      <= '0;
      last_id_q <= ID_W'(N_REQ - 1);
      rem_q     <= '0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      last_id_q <= last_id_d;
      rem_q     <= rem_d;
    end
  end

  // Next state: grant in IDLE, count bits in STREAM, wait for the consumer in RESULT
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    last_id_d = last_id_q;
    rem_d     = rem_q;
    trk_clr   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          id_d    = pick_id;
          rem_d   = pick_len;
          trk_clr = 1'b1;
          state_d = (pick_len != '0) ? ST_STREAM : ST_RESULT;
        end
      end
      ST_STREAM: begin
        if (xfer) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) state_d = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (bus.i_res_ready) begin
          last_id_d = id_q;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    bus.o_grant     = '0;
    bus.o_bit_ready = '0;
    if (state_q == ST_STREAM) begin
      bus.o_grant[id_q]     = 1'b1;
      bus.o_bit_ready[id_q] = 1'b1;
    end
    bus.o_busy      = (state_q != ST_IDLE);
    bus.o_res_valid = (state_q == ST_RESULT);
    bus.o_res_z     = (state_q == ST_RESULT) && trk_z;
    bus.o_res_id    = (state_q == ST_RESULT) ? id_q : '0;
  end

  mod3_tracker u_tracker (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (trk_clr),
    .i_en    (xfer),
    .i_bit   (bus.i_bit[id_q]),
    .o_state (trk_state),
    .o_z     (trk_z)
  );

  // The zero flag must always agree with the encoded count
  a_trk_z: assert property (@(posedge i_clk) disable iff (i_rst) trk_z == (trk_state == S0));

endmodule

// File: tb/tb_mod3_stream_arbiter.sv
module tb_mod3_stream_arbiter;
  import fsm_pkg::*;

  localparam int NR = 4;
  localparam int LW = 8;

  typedef struct {int id; int z; int len;} exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mod3_stream_arbiter_if #(.N_REQ(NR), .LEN_W(LW)) bus ();

  mod3_stream_arbiter #(.N_REQ(NR), .LEN_W(LW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;
  exp_t expq[$];
  int model_last = NR - 1;

  int cnt[NR];
  int flen[NR][2];
  logic [255:0] fb[NR][2];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int ones_in(input logic [255:0] v, input int n);
    int c = 0;
    for (int b = 0; b < n; b++) c += int'(v[b]);
    return c;
  endfunction

  task automatic clr_frames();
    for (int k = 0; k < NR; k++) begin
      cnt[k] = 0;
      for (int f = 0; f < 2; f++) begin flen[k][f] = 0; fb[k][f] = '0; end
    end
  endtask

  // Runs one batch of frames: model predicts the service order, then drives at negedges
  task automatic run_round();
    int rc[NR]; int used[NR]; int f[NR]; int idx[NR];
    bit xp[NR]; bit act[NR];
    bit acc_p; int acc_id; int cyc; int L; bit any; bit found; int j;
    for (int k = 0; k < NR; k++) begin rc[k] = cnt[k]; used[k] = 0; end
    L = model_last;
    any = 1'b1;
    while (any) begin
      found = 1'b0;
      for (int s = 1; s <= NR; s++) begin
        j = (L + s) % NR;
        if (!found && rc[j] > 0) begin
          found = 1'b1;
          expq.push_back('{j, (ones_in(fb[j][used[j]], flen[j][used[j]]) % 3 == 0) ? 1 : 0,
                           flen[j][used[j]]});
          rc[j]--; used[j]++; L = j;
        end
      end
      any = found;
    end
    model_last = L;

    @(negedge clk);
    for (int k = 0; k < NR; k++) begin
      act[k] = (cnt[k] > 0); f[k] = 0; idx[k] = 0; xp[k] = 1'b0;
      if (act[k]) begin
        bus.i_len[k*LW +: LW] = LW'(flen[k][0]);
        bus.i_req[k] = 1'b1;
      end
    end
    acc_p = 1'b0; acc_id = 0; cyc = 0;
    while (1) begin
      for (int k = 0; k < NR; k++) begin
        if (act[k] && idx[k] < flen[k][f[k]]) begin
          bus.i_bit_valid[k] = ($urandom % 4) != 0;
          bus.i_bit[k]       = fb[k][f[k]][idx[k]];
        end else begin
          bus.i_bit_valid[k] = 1'($urandom % 2);
          bus.i_bit[k]       = 1'($urandom % 2);
        end
        xp[k] = bus.o_bit_ready[k] && bus.i_bit_valid[k];
      end
      bus.i_res_ready = ($urandom % 3) != 0;
      acc_p  = bus.o_res_valid && bus.i_res_ready;
      acc_id = int'(bus.o_res_id);
      @(negedge clk);
      cyc++;
      for (int k = 0; k < NR; k++) if (xp[k]) idx[k]++;
      if (acc_p && act[acc_id]) begin
        f[acc_id]++;
        if (f[acc_id] < cnt[acc_id]) begin
          bus.i_len[acc_id*LW +: LW] = LW'(flen[acc_id][f[acc_id]]);
          idx[acc_id] = 0;
        end else begin
          bus.i_req[acc_id] = 1'b0;
          act[acc_id] = 1'b0;
        end
      end
      any = 1'b0;
      for (int k = 0; k < NR; k++) any |= act[k];
      if (!any) break;
      if (cyc > 5000) begin
        chk("round_timeout", 1, 0);
        bus.i_req = '0;
        break;
      end
    end
    bus.i_res_ready = 1'b0;
    bus.i_bit_valid = '0;
    chk("round_leftover_results", expq.size(), 0);
    expq.delete();
  endtask

  // Grant latency, drop on result, stable backpressured result and t+2 regrant
  task automatic timing_test();
    @(negedge clk);
    bus.i_req = 4'b0010; bus.i_len[1*LW +: LW] = 8'd2;
    bus.i_bit_valid = 4'b0010; bus.i_bit = 4'b0010; bus.i_res_ready = 1'b0;
    expq.push_back('{1, 0, 2});
    expq.push_back('{1, 0, 2});
    @(negedge clk); chk("grant_latency", int'(bus.o_grant), 2);
    @(negedge clk); chk("grant_held", int'(bus.o_grant), 2);
    @(negedge clk); chk("res_after_last", int'(bus.o_res_valid), 1);
    chk("grant_drop", int'(bus.o_grant), 0);
    repeat (5) begin
      @(negedge clk);
      chk("res_held", int'(bus.o_res_valid), 1);
      chk("no_grant_pending", int'(bus.o_grant), 0);
    end
    bus.i_res_ready = 1'b1;
    @(negedge clk); bus.i_res_ready = 1'b0;
    chk("idle_after_ack", int'(bus.o_busy), 0);
    chk("idle_no_grant", int'(bus.o_grant), 0);
    @(negedge clk); chk("regrant_t2", int'(bus.o_grant), 2);
    repeat (2) @(negedge clk);
    chk("res2_valid", int'(bus.o_res_valid), 1);
    bus.i_res_ready = 1'b1;
    @(negedge clk);
    bus.i_res_ready = 1'b0; bus.i_req = '0; bus.i_bit_valid = '0;
    @(negedge clk);
    chk("timing_leftover", expq.size(), 0);
    model_last = 1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_grant"}, int'(bus.o_grant), 0);
    chk({tag, "_ready"}, int'(bus.o_bit_ready), 0);
    chk({tag, "_busy"}, int'(bus.o_busy), 0);
    chk({tag, "_valid"}, int'(bus.o_res_valid), 0);
    chk({tag, "_z"}, int'(bus.o_res_z), 0);
    chk({tag, "_id"}, int'(bus.o_res_id), 0);
  endtask

  // Monitor: invariants every cycle, pops the scoreboard on each accepted result
  initial begin
    bit held; int h_id; int h_z; exp_t e;
    held = 1'b0; h_id = 0; h_z = 0;
    wait (mon_on);
    forever begin
      @(negedge clk); #4;
      if (rst) begin
        held = 1'b0;
      end else begin
        chk("busy_consistent", int'(bus.o_busy), int'((|bus.o_grant) || bus.o_res_valid));
        chk("ready_eq_grant", int'(bus.o_bit_ready), int'(bus.o_grant));
        if (held) begin
          chk("hold_valid", int'(bus.o_res_valid), 1);
          chk("hold_id", int'(bus.o_res_id), h_id);
          chk("hold_z", int'(bus.o_res_z), h_z);
        end
        if (bus.o_grant != '0 && expq.size() > 0) begin
          chk("grant_onehot_id", int'(bus.o_grant), 1 << expq[0].id);
          chk("grant_nonzero_len", int'(expq[0].len != 0), 1);
        end
        if (bus.o_res_valid && bus.i_res_ready) begin
          if (expq.size() == 0) begin
            chk("unexpected_result", 1, 0);
          end else begin
            e = expq.pop_front();
            chk("res_id", int'(bus.o_res_id), e.id);
            chk("res_z", int'(bus.o_res_z), e.z);
          end
        end
        held = bus.o_res_valid && !bus.i_res_ready;
        h_id = int'(bus.o_res_id);
        h_z  = int'(bus.o_res_z);
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.i_req = '0; bus.i_len = '0; bus.i_bit_valid = '0; bus.i_bit = '0;
    bus.i_res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    mon_on = 1'b1;

    // Requester 0, three ones
    clr_frames(); cnt[0] = 1; flen[0][0] = 3; fb[0][0] = 256'b111; run_round();
    // Requester 1, bits 1,1,0,0 with others toggling valid
    clr_frames(); cnt[1] = 1; flen[1][0] = 4; fb[1][0] = 256'b0011; run_round();
    // Requesters 0 and 2 held for two single-bit frames each
    clr_frames(); cnt[0] = 2; cnt[2] = 2;
    flen[0][0] = 1; flen[0][1] = 1; flen[2][0] = 1; flen[2][1] = 1;
    fb[0][0] = 256'b1; fb[2][1] = 256'b1; run_round();
    // Requester 3, zero-length frame
    clr_frames(); cnt[3] = 1; flen[3][0] = 0; run_round();

    timing_test();

    for (int r = 0; r < 30; r++) begin
      int r16; bit any;
      clr_frames();
      any = 1'b0;
      for (int k = 0; k < NR; k++) begin
        cnt[k] = $urandom_range(0, 2);
        if (cnt[k] > 0) any = 1'b1;
        for (int f = 0; f < 2; f++) begin
          r16 = $urandom % 16;
          flen[k][f] = (r16 == 0) ? 0 : (r16 == 1) ? 255 : $urandom_range(1, 12);
          fb[k][f] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        end
      end
      if (!any) cnt[r % NR] = 1;
      run_round();
    end

    // Reset after two of five bits, then requesters 0 and 1 from a clean state
    @(negedge clk);
    bus.i_req = 4'b0100; bus.i_len[2*LW +: LW] = 8'd5;
    bus.i_bit_valid = 4'b0100; bus.i_bit = 4'b0100;
    @(negedge clk); chk("rst_test_grant", int'(bus.o_grant), 4);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; bus.i_req = '0; bus.i_bit_valid = '0;
    @(negedge clk);
    check_reset_outputs("midframe_reset");
    rst = 1'b0;
    model_last = NR - 1;
    clr_frames(); cnt[0] = 1; cnt[1] = 1;
    flen[0][0] = 4; fb[0][0] = 256'b0111; flen[1][0] = 2; fb[1][0] = 256'b11;
    run_round();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
